// File: rtl/uart_recv_if.sv
// Byte-stream interface of the UART receiver.
// It carries the serial input and the received-byte handshake.
interface uart_recv_if;
  logic       RXD;
  logic [7:0] DATA;
  logic       DATA_READY;
  logic       FRAME_ERR;
  logic       PARITY_ERR;
  logic       BUSY;

  modport master (
    input  RXD,
    output DATA, DATA_READY, FRAME_ERR, PARITY_ERR, BUSY
  );

  modport slave (
    output RXD,
    input  DATA, DATA_READY, FRAME_ERR, PARITY_ERR, BUSY
  );
endinterface

// File: rtl/uart_recv.sv
// UART receiver: 8N1 by default, 8E1 when UART_RECV_PARITY_EN is defined.
// Samples each bit at mid-bit and holds the last good byte in a single register.
module uart_recv #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input logic       CLK,
  input logic       RST,
  uart_recv_if.master bus
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             ferr_q, ferr_d;
  logic             rxd_s;

`ifdef UART_RECV_PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad_q, par_bad_d;
`endif

  assign rxd_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RECV_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rxd_s;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RECV_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          par_bad_d = rxd_s ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
`ifdef UART_RECV_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end
`else
            data_d  = shift_q;
            ready_d = 1'b1;
`endif
          end else begin
            // Framing error wins over parity; wait out a held-low line.
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= bus.RXD;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
`ifdef UART_RECV_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign bus.DATA       = data_q;
  assign bus.DATA_READY = ready_q;
  assign bus.FRAME_ERR  = ferr_q;
  assign bus.BUSY       = (state_q != S_IDLE);
`ifdef UART_RECV_PARITY_EN
  assign bus.PARITY_ERR = perr_q;
`else
  assign bus.PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 16 clocks per bit; inputs and checks on the falling edge.
// Parity cases are built in when UART_RECV_PARITY_EN is defined.
module tb_uart_recv;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_cnt = 0;
  int   ferr_cnt = 0;
  int   perr_cnt = 0;
  int   excl_cnt = 0;
  logic [7:0] rx_q[$];

  uart_recv_if u_if ();

  uart_recv #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  // Tally output pulses cycle by cycle; a stretched pulse counts more than once.
  always @(negedge clk) begin
    if (u_if.DATA_READY === 1'b1) begin
      ready_cnt++;
      rx_q.push_back(u_if.DATA);
    end
    if (u_if.FRAME_ERR === 1'b1) ferr_cnt++;
    if (u_if.PARITY_ERR === 1'b1) perr_cnt++;
    if ((32'(u_if.DATA_READY) + 32'(u_if.FRAME_ERR) + 32'(u_if.PARITY_ERR)) > 1) excl_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    u_if.RXD = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RECV_PARITY_EN
    bit_time(par_bit);
`else
    if (par_bit === 1'bx) u_if.RXD = 1'b1;
`endif
    bit_time(stop_bit);
  endtask

  initial begin
    rst = 1'b1;
    u_if.RXD = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(u_if.DATA), 32'h00);
    chk("rst_ready", 32'(u_if.DATA_READY), 32'd0);
    chk("rst_ferr", 32'(u_if.FRAME_ERR), 32'd0);
    chk("rst_perr", 32'(u_if.PARITY_ERR), 32'd0);
    chk("rst_busy", 32'(u_if.BUSY), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after_rst", 32'(u_if.BUSY), 32'd0);

    // Two frames back to back, idle gap only half a stop bit on the receiver side
    send_frame(8'h55, 1'b1, ^8'h55);
    chk("b2b_busy_gap", 32'(u_if.BUSY), 32'd0);
    send_frame(8'hA3, 1'b1, ^8'hA3);
    repeat (4) @(negedge clk);
    chk("b2b_count", 32'(ready_cnt), 32'd2);
    chk("b2b_byte0", 32'(rx_q[0]), 32'h55);
    chk("b2b_byte1", 32'(rx_q[1]), 32'hA3);
    chk("b2b_ferr", 32'(ferr_cnt), 32'd0);
    chk("b2b_data", 32'(u_if.DATA), 32'hA3);

    // Five-cycle low glitch: shorter than half a bit
    u_if.RXD = 1'b0;
    repeat (5) @(negedge clk);
    u_if.RXD = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", 32'(u_if.BUSY), 32'd1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", 32'(u_if.BUSY), 32'd0);
    chk("glitch_ready", 32'(ready_cnt), 32'd2);
    chk("glitch_ferr", 32'(ferr_cnt), 32'd0);
    chk("glitch_data", 32'(u_if.DATA), 32'hA3);

    // Bad stop bit followed by a held-low line
    send_frame(8'h39, 1'b0, ^8'h39);
    repeat (40) @(negedge clk);
    chk("ferr_pulse", 32'(ferr_cnt), 32'd1);
    chk("ferr_busy", 32'(u_if.BUSY), 32'd1);
    chk("ferr_data", 32'(u_if.DATA), 32'hA3);
    chk("ferr_ready", 32'(ready_cnt), 32'd2);
    u_if.RXD = 1'b1;
    repeat (5) @(negedge clk);
    chk("ferr_release", 32'(u_if.BUSY), 32'd0);
    send_frame(8'h30, 1'b1, ^8'h30);
    repeat (4) @(negedge clk);
    chk("post_ferr_count", 32'(ready_cnt), 32'd3);
    chk("post_ferr_byte", 32'(rx_q[2]), 32'h30);
    chk("post_ferr_data", 32'(u_if.DATA), 32'h30);

    // Full-rate stream "0".."9"
    for (int i = 0; i < 10; i++) begin
      logic [7:0] c;
      c = 8'h30 + 8'(i);
      send_frame(c, 1'b1, ^c);
    end
    repeat (4) @(negedge clk);
    chk("stream_count", 32'(ready_cnt), 32'd13);
    for (int i = 0; i < 10; i++) chk($sformatf("stream_byte%0d", i), 32'(rx_q[3+i]), 32'h30 + 32'(i));
    chk("stream_ferr", 32'(ferr_cnt), 32'd1);

    // Reset asserted in the middle of data bit 4
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0]);
    u_if.RXD = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_data", 32'(u_if.DATA), 32'h00);
    chk("midrst_busy", 32'(u_if.BUSY), 32'd0);
    chk("midrst_ready", 32'(u_if.DATA_READY), 32'd0);
    chk("midrst_ferr", 32'(u_if.FRAME_ERR), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (32) @(negedge clk);
    chk("midrst_no_pulse", 32'(ready_cnt), 32'd13);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    repeat (4) @(negedge clk);
    chk("after_rst_count", 32'(ready_cnt), 32'd14);
    chk("after_rst_data", 32'(u_if.DATA), 32'h7E);
    chk("after_rst_ferr", 32'(ferr_cnt), 32'd1);

`ifdef UART_RECV_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_good_count", 32'(ready_cnt), 32'd15);
    chk("par_good_data", 32'(u_if.DATA), 32'h07);
    chk("par_good_perr", 32'(perr_cnt), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("par_bad_perr", 32'(perr_cnt), 32'd1);
    chk("par_bad_count", 32'(ready_cnt), 32'd15);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_bad2_perr", 32'(perr_cnt), 32'd2);
    chk("par_bad2_data", 32'(u_if.DATA), 32'h07);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_ferr_prio_ferr", 32'(ferr_cnt), 32'd2);
    chk("par_ferr_prio_perr", 32'(perr_cnt), 32'd2);
    u_if.RXD = 1'b1;
    repeat (5) @(negedge clk);
`else
    chk("no_parity_err", 32'(perr_cnt), 32'd0);
`endif
    chk("exclusive_pulses", 32'(excl_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART 8N1 receiver. Deserialises the board RXD line into bytes for the design's byte-stream consumers, such as the loopback/command logic that feeds uart_send.
- Same DATA/DATA_READY byte handshake convention as uart_send, so a received byte can be forwarded to the transmitter directly.
- Mid-bit sampling off a per-bit clock counter; no FIFO (single holding register).

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per bit (100 MHz / 115200); must be >= 4.
- CNT_W, 16, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, asynchronous, active-high
- RXD  input  1  asynchronous serial line, idle high
- DATA  output  8  last correctly framed byte, LSB received first
- DATA_READY  output  1  one-cycle pulse when DATA is updated
- FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low
- PARITY_ERR  output  1  one-cycle pulse on parity mismatch (see Optional Feature)
- BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (CLK, RST).
  - While RST is high: DATA=8'h00, DATA_READY=0, FRAME_ERR=0, PARITY_ERR=0, BUSY=0, state=IDLE, counters=0.
  - Both synchroniser flops reset to 1, so no spurious start follows reset.
  - RST asserted mid-frame abandons the frame with no pulse.
- Synchroniser: RXD passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rxd_s==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1 (integer divide), sample rxd_s.
    - Sample 1: false start, go to IDLE, no pulse.
    - Sample 0: go to DATA, cnt=0, bit_idx=0.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rxd_s into shift register bit bit_idx (LSB first) and reset cnt. After bit_idx 7 is sampled -> STOP (or PARITY when the feature is enabled).
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxd_s.
    - Sample 1: next cycle DATA <= shift register, DATA_READY=1 for exactly one cycle, state -> IDLE.
    - Sample 0: FRAME_ERR=1 for one cycle, DATA unchanged, state -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s==1 (break/line-low handling), then IDLE.
- Latency: DATA_READY rises 1 cycle after the mid-stop sample, about (9.5*CLKS_PER_BIT + 3) cycles after the RXD falling edge (includes the 2-flop synchroniser delay).
- Back-to-back frames: a new start bit can be detected on the cycle after returning to IDLE. No idle gap is required beyond the half stop bit.
- Overrun: no buffering. DATA is held until the next good frame overwrites it. The consumer must capture DATA on the DATA_READY cycle; no overrun flag.
- DATA_READY, FRAME_ERR and PARITY_ERR are mutually exclusive in any cycle.
- Counter never wraps: it is always cleared at every sample point.

Optional Feature:
- Macro: UART_RECV_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state is inserted between DATA and STOP and sampled at cnt==CLKS_PER_BIT-1.
  - The expected parity bit is the XOR of the 8 data bits, so data plus parity has even parity.
  - On mismatch the stop bit is still checked.
    - Good stop: PARITY_ERR pulses instead of DATA_READY, and DATA is unchanged.
    - Bad stop: FRAME_ERR takes priority and PARITY_ERR stays 0.
- Undefined: no PARITY state; PARITY_ERR is tied 0.

Test Plan:
- CLKS_PER_BIT=16; send 0x55 then 0xA3 back-to-back -> DATA=0x55 with a 1-cycle DATA_READY, then DATA=0xA3 with a 1-cycle DATA_READY; FRAME_ERR stays 0; BUSY low between frames.
- RXD low glitch of 5 cycles (shorter than the half bit of 8) -> BUSY pulses, returns to IDLE, no DATA_READY/FRAME_ERR; DATA unchanged.
- Send 0x39 with stop bit 0, then hold RXD low 40 cycles, then release -> FRAME_ERR one pulse, DATA retains the previous value, BUSY high until RXD high, then a following 0x30 is received correctly.
- Stream "0".."9" (0x30–0x39) at full rate, with the bench capturing DATA on each DATA_READY -> 10 pulses, bytes in order, no errors.
- Assert RST for 3 cycles during bit 4 of a frame -> all outputs 0 immediately (asynchronously), no pulse; the next full frame 0x7E is received correctly.
- With UART_RECV_PARITY_EN: 0x07 with parity 1 -> DATA_READY; 0x07 with parity 0 -> PARITY_ERR, DATA unchanged.
